// File: rtl/seg7_reader.sv
// Reads four active-low 7-segment digit patterns, waits for them to settle,
// then decodes them into a 16-bit BCD value with per-digit error flags.
module seg7_reader #(
    parameter int unsigned STABLE_CNT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [0:6]  HEX0,
    input  logic [0:6]  HEX1,
    input  logic [0:6]  HEX2,
    input  logic [0:6]  HEX3,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        busy,
    output logic [15:0] value,
    output logic [3:0]  err,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, SETTLE, DECODE, HOLD} state_t;

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_CNT);
    localparam logic [7:0] TIMER_LAST = 8'd254;

    state_t      state;
    logic [27:0] snap;
    logic [27:0] live;
    logic [3:0]  stable_cnt;
    logic [7:0]  timer;
    logic [1:0]  idx;
    logic [4:0]  dec;

    // {err, nibble} for one active-low pattern, bit 0 = segment a
    function automatic logic [4:0] seg_decode(input logic [0:6] p);
        logic [4:0] r;
        case (p)
            7'b0000001: r = 5'h00;
            7'b1001111: r = 5'h01;
            7'b0010010: r = 5'h02;
            7'b0000110: r = 5'h03;
            7'b1001100: r = 5'h04;
            7'b0100100: r = 5'h05;
            7'b0100000: r = 5'h06;
            7'b0001101: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0000100: r = 5'h09;
            7'b1111111: r = 5'h0F;
            default:    r = 5'h1E;
        endcase
        return r;
    endfunction

    always_comb begin
        live = {HEX3, HEX2, HEX1, HEX0};
        dec  = seg_decode(snap[7*idx +: 7]);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            snap       <= '0;
            stable_cnt <= '0;
            timer      <= '0;
            idx        <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            value      <= '0;
            err        <= '0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap       <= live;
                        stable_cnt <= '0;
                        timer      <= '0;
                        timeout    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    timer <= timer + 8'd1;
                    // A completed stability run wins over a timer expiring on the same cycle
                    if (stable_cnt == STABLE_LIM) begin
                        idx   <= '0;
                        state <= DECODE;
                    end else if (timer == TIMER_LAST) begin
                        value     <= 16'hEEEE;
                        err       <= 4'hF;
                        timeout   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (live == snap) begin
                        stable_cnt <= stable_cnt + 4'd1;
                    end else begin
                        snap       <= live;
                        stable_cnt <= '0;
                    end
                end
                DECODE: begin
                    value[{idx, 2'b00} +: 4] <= dec[3:0];
                    err[idx]                 <= dec[4];
                    idx                      <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: expected results queued at start, compared when out_valid rises.
module tb_seg7_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [0:6]  HEX0, HEX1, HEX2, HEX3;
    logic        out_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] value;
    logic [3:0]  err;
    logic        timeout;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  e;
        logic        t;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [0:6] pat [10];
    logic [0:6] blank = 7'b1111111;

    seg7_reader #(.STABLE_CNT(2)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .out_ready(out_ready), .out_valid(out_valid), .busy(busy),
        .value(value), .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic set_hex(input logic [0:6] h0, input logic [0:6] h1,
                           input logic [0:6] h2, input logic [0:6] h3);
        @(negedge clk);
        HEX0 = h0; HEX1 = h1; HEX2 = h2; HEX3 = h3;
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] e, input logic t);
        exp_t x;
        x.v = v; x.e = e; x.t = t;
        sb.push_back(x);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic collect(input string tag, input int exp_lat);
        int   lat;
        exp_t x;
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_sb"}, sb.size(), 1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, "_value"}, value, x.v);
            chk({tag, "_err"}, err, x.e);
            chk({tag, "_timeout"}, timeout, x.t);
        end
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_ack_valid"}, out_valid, 0);
        chk({tag, "_ack_busy"}, busy, 0);
    endtask

    initial begin
        pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010;
        pat[3] = 7'b0000110; pat[4] = 7'b1001100; pat[5] = 7'b0100100;
        pat[6] = 7'b0100000; pat[7] = 7'b0001101; pat[8] = 7'b0000000;
        pat[9] = 7'b0000100;

        resetn = 1'b0; start = 1'b0; out_ready = 1'b0;
        HEX0 = blank; HEX1 = blank; HEX2 = blank; HEX3 = blank;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_value", value, 0);
        chk("rst_err", err, 0);
        chk("rst_timeout", timeout, 0);
        @(negedge clk) resetn = 1'b1;

        // digits 0..3
        set_hex(pat[0], pat[1], pat[2], pat[3]);
        push(16'h3210, 4'h0, 1'b0);
        do_start();
        chk("c1_busy", busy, 1);
        collect("c1", 7);
        ack("c1");
        chk("c1_retain", value, 16'h3210);

        // 7,8,9,blank
        set_hex(pat[7], pat[8], pat[9], blank);
        push(16'hF987, 4'h0, 1'b0);
        do_start();
        collect("c2", 7);
        ack("c2");

        // unrecognised pattern on digit 1
        set_hex(pat[0], 7'b1010101, pat[0], pat[0]);
        push(16'h00E0, 4'b0010, 1'b0);
        do_start();
        collect("c3", 7);
        ack("c3");

        // random valid digits
        for (int n = 0; n < 4; n++) begin
            int d [4];
            for (int i = 0; i < 4; i++) d[i] = $urandom_range(9);
            set_hex(pat[d[0]], pat[d[1]], pat[d[2]], pat[d[3]]);
            push({4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])}, 4'h0, 1'b0);
            do_start();
            collect("rnd", 7);
            ack("rnd");
        end

        // HEX0 never settles: timeout after 255 settle cycles
        set_hex(pat[0], pat[1], pat[2], pat[3]);
        push(16'hEEEE, 4'hF, 1'b1);
        do_start();
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    HEX0 = (HEX0 == pat[0]) ? pat[1] : pat[0];
                end
            end
            collect("tmo", 255);
        join
        ack("tmo");
        chk("tmo_retain", timeout, 1);

        // HOLD stalls for 10 cycles, start during HOLD ignored
        set_hex(pat[0], pat[1], pat[2], pat[3]);
        push(16'h3210, 4'h0, 1'b0);
        do_start();
        chk("hold_clr_timeout", timeout, 0);
        collect("hold", 7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 5);
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_value", value, 16'h3210);
        end
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; out_ready = 1'b0;
        chk("hold_exit_valid", out_valid, 0);
        chk("hold_exit_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_not_queued", busy, 0);
        chk("hold_retain", value, 16'h3210);

        // reset while decoding digit 2
        set_hex(pat[0], pat[1], pat[2], pat[3]);
        do_start();
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_value", value, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_timeout", timeout, 0);
        @(negedge clk) resetn = 1'b1;
        push(16'h3210, 4'h0, 1'b0);
        do_start();
        collect("post_rst", 7);
        ack("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 The block SHALL have one parameter: STABLE_CNT, default 2, the number of consecutive cycles the live patterns must match the snapshot before decode (legal range 1..15).
REQ-002 Port clk, input, 1 bit: the only clock; all state SHALL update on its rising edge.
REQ-003 Port resetn, input, 1 bit: reset is synchronous and active-low.
REQ-004 Port start, input, 1 bit: request to read all four digits; sampled only in IDLE.
REQ-005 Ports HEX0, HEX1, HEX2, HEX3, input, [0:6] each: active-low segment patterns for digits 0..3 (bit 0 = segment a).
REQ-006 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-007 Port out_valid, output, 1 bit: the result on value, err and timeout is valid.
REQ-008 Port busy, output, 1 bit: high in every state except IDLE.
REQ-009 Port value, output, 16 bits: decoded nibbles, with digit i at value[4i+3:4i].
REQ-010 Port err, output, 4 bits: bit i high means digit i held an unrecognised pattern.
REQ-011 Port timeout, output, 1 bit: the settle phase expired.

Function
REQ-012 The block SHALL implement a four-state FSM: IDLE, SETTLE, DECODE, HOLD.
REQ-013 IDLE: on start=1, the block SHALL latch all four HEX inputs into a snapshot, clear the stability counter and the 8-bit settle timer, clear timeout, and go to SETTLE.
REQ-014 SETTLE, matching cycle: live inputs equal the snapshot; the stability counter SHALL increment, and after STABLE_CNT consecutive matching cycles the FSM SHALL go to DECODE with digit index 0.
REQ-015 SETTLE, mismatch cycle: the block SHALL re-latch the snapshot from the live inputs and reset the stability counter to 0.
REQ-016 SETTLE timer: it SHALL increment every SETTLE cycle; when it reaches 255 without exit, the block SHALL load value=16'hEEEE, err=4'hF and timeout=1, and go to HOLD.
REQ-017 DECODE: the block SHALL decode one snapshot digit per cycle, index 0..3, writing its nibble and err bit; after index 3 it SHALL go to HOLD.
REQ-018 Pattern map (active-low, bits 0..6), patterns 0 to 4:
- 0000001 -> 0
- 1001111 -> 1
- 0010010 -> 2
- 0000110 -> 3
- 1001100 -> 4
REQ-019 Pattern map, patterns 5 to 9:
- 0100100 -> 5
- 0100000 -> 6
- 0001101 -> 7
- 0000000 -> 8
- 0000100 -> 9
REQ-020 A blank pattern 1111111 SHALL decode to nibble F with err bit 0.
REQ-021 Any other pattern SHALL decode to nibble E with err bit 1.
REQ-022 HOLD: out_valid SHALL be 1, and value, err and timeout SHALL be stable until out_ready=1.
REQ-023 HOLD exit: when out_ready=1, the FSM SHALL go to IDLE and out_valid SHALL be 0 from the next cycle.
REQ-024 Latency: with inputs stable, a start sampled at edge k SHALL give out_valid=1 from edge k+STABLE_CNT+5 (k+7 at default).
REQ-025 A start while busy=1 SHALL be ignored, including in a HOLD cycle where out_ready=1; it is not queued.
REQ-026 After a HOLD exit, value, err and timeout SHALL keep their last values until the next start is accepted.

Reset
REQ-027 With resetn=0 at a clock edge, the block SHALL enter IDLE and clear all state: busy=0, out_valid=0, value=16'h0000, err=4'h0, timeout=0, snapshot and counters 0.
REQ-028 Reset in any state, including mid-SETTLE, mid-DECODE or HOLD, SHALL abort the operation with no partial result.

Verification
REQ-029 HEX0..3 = 0000001, 1001111, 0010010, 0000110, held stable; start pulse -> out_valid at edge k+7, value=16'h3210, err=0, timeout=0.
REQ-030 HEX0..3 = 0001101, 0000000, 0000100, 1111111; start -> value=16'hF987, err=4'b0000.
REQ-031 HEX1=1010101, other digits valid 0s; start -> value=16'h00E0, err=4'b0010.
REQ-032 HEX0 toggles between 0000001 and 1001111 every cycle for 300 cycles after start -> out_valid after 255 SETTLE cycles, value=16'hEEEE, err=4'hF, timeout=1.
REQ-033 out_ready held 0 for 10 HOLD cycles with a start pulse during HOLD -> outputs held and start ignored; out_ready=1 -> IDLE next cycle with out_valid=0.
REQ-034 resetn=0 during DECODE index 2 -> next edge all outputs 0 and state IDLE; a following start with case REQ-029 inputs -> value=16'h3210.
